// File: rtl/byte_memory_sequencer_pkg.sv
// Shared encodings for the memory address handler, byte sequencer and control unit.
package byte_memory_sequencer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // Address handler output when the stack is empty; always out of range.
  localparam logic [31:0] EMPTY_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] wdata;
  } req_t;

  // Index of the highest byte lane used by an access of the given size.
  function automatic logic [1:0] last_lane(input logic [1:0] size);
    logic [1:0] lane;
    case (size)
      SZ_HALF: lane = 2'd1;
      SZ_WORD: lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/byte_memory_sequencer_lane.sv
// Combinational 4:1 lane mux/demux: picks address and store byte for one lane,
// and steers a captured read byte into its lane of the load assembly word.
module byte_lane_select
  import byte_memory_sequencer_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [3:0][ADDR_W-1:0] addr,
  input  logic [31:0]            wdata,
  input  logic [1:0]             sel_idx,
  input  logic [31:0]            asm_in,
  input  logic [1:0]             cap_idx,
  input  logic [7:0]             cap_byte,
  output logic [ADDR_W-1:0]      sel_addr,
  output logic [7:0]             sel_byte,
  output logic [31:0]            asm_out
);

  always_comb begin
    sel_addr = addr[sel_idx];
    sel_byte = wdata[8*sel_idx +: 8];
    asm_out  = asm_in;
    asm_out[8*cap_idx +: 8] = cap_byte;
  end

endmodule

// File: rtl/byte_memory_sequencer.sv
// Performs 1/2/4 byte accesses one per cycle against a sync-read byte memory; loads assembled, stores split.
// Done 6 cycles after accept for a word load (5 word store, 1 on error); start is ignored, not queued, while busy.
module byte_memory_sequencer
  import byte_memory_sequencer_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic [31:0]       byte3,
  input  logic [31:0]       byte2,
  input  logic [31:0]       byte1,
  input  logic [31:0]       byte0,
  input  logic [31:0]       wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t                 state;
  req_t                   req;
  logic [3:0][ADDR_W-1:0] req_addr;
  logic [1:0]             idx;
  logic                   first;
  logic [31:0]            asm_q;

  logic [3:0][31:0]       in_addr;
  logic [3:0][ADDR_W-1:0] in_trunc;
  logic [3:0][ADDR_W-1:0] src_addr;
  logic [31:0]            src_wdata;
  logic [1:0]             sel_idx;
  logic [1:0]             cap_idx;
  logic [ADDR_W-1:0]      sel_addr;
  logic [7:0]             sel_byte;
  logic [31:0]            asm_next;
  logic                   range_err;

  assign in_addr = {byte3, byte2, byte1, byte0};

  // Range is judged on the full 32-bit address; truncation only happens after.
  always_comb begin
    in_trunc  = '0;
    range_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_trunc[k] = in_addr[k][ADDR_W-1:0];
      if (k <= int'(last_lane(size)) && (in_addr[k][31:ADDR_W] != '0))
        range_err = 1'b1;
    end
  end

  // In IDLE the first address is chosen straight from the inputs being accepted.
  assign src_addr  = (state == ST_IDLE) ? in_trunc : req_addr;
  assign src_wdata = (state == ST_IDLE) ? wdata : req.wdata;
  assign sel_idx   = (state == ST_IDLE) ? last_lane(size) : idx - 2'd1;
  assign cap_idx   = (state == ST_DRAIN) ? 2'd0 : idx + 2'd1;

  byte_lane_select #(.ADDR_W(ADDR_W)) u_lane (
    .addr     (src_addr),
    .wdata    (src_wdata),
    .sel_idx  (sel_idx),
    .asm_in   (asm_q),
    .cap_idx  (cap_idx),
    .cap_byte (mem_rdata),
    .sel_addr (sel_addr),
    .sel_byte (sel_byte),
    .asm_out  (asm_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req       <= '0;
      req_addr  <= '0;
      idx       <= 2'd0;
      first     <= 1'b0;
      asm_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            req.write <= write;
            req.wdata <= wdata;
            req_addr  <= in_trunc;
            busy      <= 1'b1;
            if (size == SZ_RSVD || range_err) begin
              error <= 1'b1;
              rdata <= EMPTY_MARKER;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              error     <= 1'b0;
              idx       <= last_lane(size);
              first     <= 1'b1;
              asm_q     <= '0;
              mem_addr  <= sel_addr;
              mem_we    <= write;
              mem_wdata <= write ? sel_byte : 8'h00;
              state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          first <= 1'b0;
          // Read data trails the address by one cycle, so it belongs to lane idx+1.
          if (!req.write && !first)
            asm_q <= asm_next;
          if (idx == 2'd0) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            if (req.write) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            idx       <= idx - 2'd1;
            mem_addr  <= sel_addr;
            mem_we    <= req.write;
            mem_wdata <= req.write ? sel_byte : 8'h00;
          end
        end
        ST_DRAIN: begin
          rdata <= asm_next;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_memory_sequencer.sv
// Directed bench for byte_memory_sequencer: a transaction-level model predicts every cycle's outputs.
module tb_byte_memory_sequencer;

  localparam int ADDR_W    = 14;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              write;
  logic [1:0]        size;
  logic [31:0]       byte3, byte2, byte1, byte0;
  logic [31:0]       wdata;
  logic [7:0]        mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [31:0]       rdata;
  logic              busy, done, error;

  byte_memory_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .write     (write),
    .size      (size),
    .byte3     (byte3),
    .byte2     (byte2),
    .byte1     (byte1),
    .byte0     (byte0),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  // Environment memory: byte-wide, synchronous read (old data on a same-cycle write).
  logic [7:0] mem [MEM_BYTES];
  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  // Reference model state.
  logic [7:0]        ref_mem [MEM_BYTES];
  logic [31:0]       model_rdata = '0;
  bit                model_err   = 1'b0;
  bit                t_active    = 1'b0;
  int                t_cyc       = 0;
  bit                exp_err, exp_wr;
  int                exp_n, exp_done;
  logic [ADDR_W-1:0] exp_addr [4];
  logic [7:0]        exp_byte [4];
  logic [31:0]       exp_rdata;
  bit                cmp_acc;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_total++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req_v, $time);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"},     rdata,          32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_error"},     32'(error),     32'd0);
  endtask

  // One compare process: every cycle out of reset, DUT outputs versus the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (t_active) begin
        cmp_acc = !exp_err && (t_cyc <= exp_n);
        chk("mem_we", 32'(mem_we), 32'(cmp_acc && exp_wr));
        chk("mem_addr", 32'(mem_addr), cmp_acc ? 32'(exp_addr[t_cyc-1]) : 32'd0);
        if (exp_wr || !cmp_acc)
          chk("mem_wdata", 32'(mem_wdata), (cmp_acc && exp_wr) ? 32'(exp_byte[t_cyc-1]) : 32'd0);
        chk("busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'(t_cyc == exp_done));
        chk("error", 32'(error), 32'(exp_err));
        if (t_cyc == exp_done) chk("rdata_at_done", rdata, exp_rdata);
      end else begin
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        chk("idle_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_error", 32'(error), 32'(model_err));
        chk("idle_rdata", rdata, model_rdata);
      end
    end
  end

  // Issue one request; the model predicts order, latency and data from the access rules.
  task automatic run(input bit wr, input logic [1:0] sz,
                     input logic [31:0] a3, input logic [31:0] a2,
                     input logic [31:0] a1, input logic [31:0] a0,
                     input logic [31:0] wd, input bit hold_start, input int abort_cyc);
    logic [31:0] a [4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    exp_wr  = wr;
    exp_n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    exp_err = (sz == 2'd3);
    for (int k = 0; k < exp_n; k++)
      if (a[k] >= 32'(MEM_BYTES)) exp_err = 1'b1;
    for (int c = 0; c < exp_n; c++) begin
      exp_addr[c] = a[exp_n-1-c][ADDR_W-1:0];
      exp_byte[c] = wd[8*(exp_n-1-c) +: 8];
    end
    if (exp_err) begin
      exp_done  = 1;
      exp_rdata = 32'hFFFF_FFFF;
    end else if (wr) begin
      exp_done  = exp_n + 1;
      exp_rdata = model_rdata;
    end else begin
      exp_done  = exp_n + 2;
      exp_rdata = '0;
      for (int k = 0; k < exp_n; k++)
        exp_rdata[8*k +: 8] = ref_mem[a[k][ADDR_W-1:0]];
    end

    @(negedge clock);
    start = 1'b1; write = wr; size = sz;
    byte3 = a3; byte2 = a2; byte1 = a1; byte0 = a0; wdata = wd;
    @(posedge clock);
    t_cyc    = 1;
    t_active = 1'b1;
    #1;
    if (!hold_start) start = 1'b0;
    while (t_cyc < exp_done) begin
      @(posedge clock);
      if (wr && !exp_err && t_cyc <= exp_n)
        ref_mem[exp_addr[t_cyc-1]] = exp_byte[t_cyc-1];
      t_cyc++;
      if (t_cyc == abort_cyc) begin
        #1;
        reset       = 1'b1;
        t_active    = 1'b0;
        model_rdata = '0;
        model_err   = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        return;
      end
    end
    @(posedge clock);
    model_rdata = exp_rdata;
    model_err   = exp_err;
    t_active    = 1'b0;
    #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; write = 1'b0; size = 2'd0;
    byte3 = '0; byte2 = '0; byte1 = '0; byte0 = '0; wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[14'h17FD] = 8'h11; mem[14'h17FE] = 8'h22; mem[14'h17FF] = 8'h33; mem[14'h1800] = 8'h44;
    mem[14'h0100] = 8'hBE; mem[14'h0101] = 8'hEF; mem[14'h3FFF] = 8'h5A;
    ref_mem[14'h17FD] = 8'h11; ref_mem[14'h17FE] = 8'h22; ref_mem[14'h17FF] = 8'h33; ref_mem[14'h1800] = 8'h44;
    ref_mem[14'h0100] = 8'hBE; ref_mem[14'h0101] = 8'hEF; ref_mem[14'h3FFF] = 8'h5A;

    #12;
    check_reset_vals("por");
    @(negedge clock);
    reset = 1'b0;

    run(1'b0, 2'd2, 32'h17FD, 32'h17FE, 32'h17FF, 32'h1800, 32'h0, 1'b0, 0);
    chk("pin_word_load", rdata, 32'h1122_3344);

    run(1'b1, 2'd2, 32'h17FD, 32'h17FE, 32'h17FF, 32'h1800, 32'hA1B2_C3D4, 1'b0, 0);
    chk("pin_store_17fd", 32'(mem[14'h17FD]), 32'h0000_00A1);
    chk("pin_store_17fe", 32'(mem[14'h17FE]), 32'h0000_00B2);
    chk("pin_store_17ff", 32'(mem[14'h17FF]), 32'h0000_00C3);
    chk("pin_store_1800", 32'(mem[14'h1800]), 32'h0000_00D4);
    chk("pin_store_keeps_rdata", rdata, 32'h1122_3344);

    run(1'b0, 2'd1, 32'h0, 32'h0, 32'h0100, 32'h0101, 32'h0, 1'b0, 0);
    chk("pin_half_load", rdata, 32'h0000_BEEF);

    run(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0101, 32'h0, 1'b0, 0);
    chk("pin_byte_load", rdata, 32'h0000_00EF);

    run(1'b0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    chk("pin_empty_rdata", rdata, 32'hFFFF_FFFF);
    chk("pin_empty_error", 32'(error), 32'd1);

    run(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0101, 32'h0, 1'b0, 0);
    chk("pin_error_cleared", 32'(error), 32'd0);

    run(1'b0, 2'd3, 32'h0, 32'h0, 32'h0100, 32'h0101, 32'h0, 1'b0, 0);
    chk("pin_rsvd_error", 32'(error), 32'd1);
    chk("pin_rsvd_rdata", rdata, 32'hFFFF_FFFF);

    // Top legal address, with an out-of-range address in an unused lane.
    run(1'b0, 2'd0, 32'h0, 32'h0, 32'h4000, 32'h3FFF, 32'h0, 1'b0, 0);
    chk("pin_top_addr", rdata, 32'h0000_005A);

    run(1'b1, 2'd1, 32'h0, 32'h0, 32'h4000, 32'h0100, 32'h0000_1234, 1'b0, 0);
    chk("pin_oor_store_error", 32'(error), 32'd1);
    chk("pin_oor_store_nowrite", 32'(mem[14'h0100]), 32'h0000_00BE);

    run(1'b1, 2'd2, 32'h17FD, 32'h17FE, 32'h17FF, 32'h1800, 32'h5566_7788, 1'b0, 2);
    chk("pin_abort_byte3", 32'(mem[14'h17FD]), 32'h0000_0055);
    chk("pin_abort_byte2", 32'(mem[14'h17FE]), 32'h0000_00B2);
    chk("pin_abort_byte0", 32'(mem[14'h1800]), 32'h0000_00D4);

    run(1'b1, 2'd2, 32'h17FD, 32'h17FE, 32'h17FF, 32'h1800, 32'h99AA_BBCC, 1'b0, 0);
    chk("pin_restore_17fe", 32'(mem[14'h17FE]), 32'h0000_00AA);
    chk("pin_restore_1800", 32'(mem[14'h1800]), 32'h0000_00CC);

    run(1'b0, 2'd2, 32'h17FD, 32'h17FE, 32'h17FF, 32'h1800, 32'h0, 1'b1, 0);
    chk("pin_busy_start_load", rdata, 32'h99AA_BBCC);

    @(negedge clock);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/byte_memory_sequencer.md
# byte_memory_sequencer

Multi-cycle sequencer that sits directly downstream of the memory address handler. It takes the up-to-four per-byte addresses the handler produces (Byte3..Byte0) and performs the accesses one byte per cycle against a byte-wide, synchronous-read data memory. Loads are assembled into a 32-bit word; stores are split into bytes. It reports completion to the control unit with a `done` pulse and flags illegal addresses, including the 0xFFFFFFFF empty-stack marker.

## Interface
- `ADDR_W`, 14: memory byte-address width. The memory holds `2**ADDR_W` bytes.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `write`  in  1: 1 = store, 0 = load; latched at accept.
- `size`  in  2: 0 = byte (Byte0), 1 = half (Byte1, Byte0), 2 = word (Byte3..Byte0), 3 = reserved; latched at accept.
- `byte3`, `byte2`, `byte1`, `byte0`  in  32 each: byte addresses from the address handler; latched at accept.
- `wdata`  in  32: store data; lane k (`wdata[8k+7:8k]`) goes to address `byte_k`; latched at accept.
- `mem_rdata`  in  8: memory read data, valid the cycle after `mem_addr` is presented.
- `mem_addr`  out  ADDR_W: byte address to memory.
- `mem_wdata`  out  8: byte to write.
- `mem_we`  out  1: write enable.
- `rdata`  out  32: assembled load result. Byte from `byte_k` lands at `[8k+7:8k]`; unused lanes are zero.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `error`  out  1: qualifies `done`; held until the next accept.

## Operation
- **States:** IDLE, ACCESS, DRAIN, DONE.
- **Byte count:** n = 1, 2 or 4 for size 0/1/2.
- **IDLE, on `start`:**
  - Latch all inputs.
  - If `size==3`, or any used address is ≥ `2**ADDR_W`: go to DONE with `error=1`. No memory cycle occurs, and `rdata` is set to 32'hFFFFFFFF.
  - Otherwise clear `error` and go to ACCESS with index `i = n-1`.
- **ACCESS:**
  - Drive `mem_addr = byte_i[ADDR_W-1:0]`.
  - On a store, also drive `mem_we=1` and `mem_wdata = wdata lane i`.
  - Decrement `i`. This yields ascending-address order (Byte(n-1) first, Byte0 last).
  - On a load, capture `mem_rdata` into lane i+1 in each cycle after the first issue.
  - After `i==0` is issued: a load goes to DRAIN, a store goes to DONE.
- **DRAIN:** capture lane 0 from `mem_rdata`, then go to DONE. `mem_we=0`.
- **DONE:** `done=1` for one cycle, then go to IDLE.
  - `rdata` holds until the next accepted load or error.
  - A store leaves `rdata` unchanged.
- **`start` while `busy`:** ignored, not queued.
- **`mem_we`:** asserted only in ACCESS on a store. `mem_addr` and `mem_wdata` are 0 outside ACCESS.
- **Width rule:** addresses are compared as full 32-bit unsigned values before truncation to ADDR_W. There is no wrap-around; out-of-range is an error.

## Timing
- Reset values: state=IDLE; `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `rdata`=0, `busy`=0, `done`=0, `error`=0.
- Reset mid-operation: immediate return to IDLE, `mem_we` drops asynchronously, and no further bytes are written. A partially written word is not rolled back.
- Accept at edge E0 (cycle 0). Latencies to the `done` cycle, counted from cycle 0:
  - Word load: ACCESS in cycles 1–4, DRAIN in 5, `done` in 6.
  - Half load: `done` in cycle 4.
  - Byte load: `done` in cycle 3.
  - Word store: `done` in cycle 5.
  - Byte store: `done` in cycle 2.
  - Error: `done` in cycle 1.
- `start` sampled in the same cycle as DONE is ignored. The earliest next accept is the cycle after `done`.

## Structure
- Shared header, common with the address handler and control unit, holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings;
  - the EMPTY_MARKER constant 32'hFFFFFFFF.
- One natural sub-module, `byte_lane_select`: a combinational 4:1 lane mux/demux. It selects the address and write byte for index i and steers captured read bytes into `rdata` lanes. The FSM, counter and capture registers stay in the top module.

## Test plan
- **Word load:** bytes 0x17FD..0x1800 preloaded with 11,22,33,44; size=2, byte3..0=0x17FD..0x1800 → `mem_addr` sequence 0x17FD,0x17FE,0x17FF,0x1800; `done` in cycle 6; `rdata`=0x11223344 (byte3 in [31:24], byte0 in [7:0]); `error`=0.
- **Word store:** wdata=0xA1B2C3D4, same addresses → four writes 0x17FD←A1, 0x17FE←B2, 0x17FF←C3, 0x1800←D4; `done` in cycle 5; memory readback matches.
- **Half/byte loads:** size=1, byte1..0=0x0100/0x0101 holding 0xBE,0xEF → `rdata`=0x0000BEEF in cycle 4. Size=0 → `rdata`=0x000000EF in cycle 3.
- **Empty marker:** all addresses 0xFFFFFFFF → no `mem_we`/`mem_addr` activity; `done`+`error` in cycle 1; `rdata`=0xFFFFFFFF. Repeat with size=3 → same response.
- **Reset mid-store:** assert `reset` in cycle 2 of a word store → only byte3's write has occurred; outputs take their reset values immediately; the next store completes normally.
- **Busy start:** `start` pulsed each cycle during a word load → exactly one `done`; `rdata` unaffected by the ignored requests.
